// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store unit bus sequencer for a single-issue RV32I core.
//
// Takes one load or store request from the core, checks alignment, runs a
// single bus transfer on a simple valid/ready bus, and returns the formatted
// load result with a one-cycle done pulse. The core is stalled while the
// transfer is in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_rd, req_wr      core load / store request (both high = store)
//   req_addr            byte address
//   req_wdata           unaligned store data
//   req_func3           RV32I load/store func3 (size and sign)
//   stall               core must hold PC and request
//   load_data           formatted load result, valid with done
//   done                one-cycle completion pulse
//   misaligned          one-cycle rejection pulse, no bus cycle issued
//   bus_err             one-cycle pulse with done on a timed-out access
//   bus_valid, bus_we   bus request and write enable
//   bus_addr            word address (bits [1:0] always zero)
//   bus_wdata, bus_be   lane-replicated store data and byte enables
//   bus_ready           slave accept/complete, qualified by bus_valid
//   bus_rdata           read word, valid in the bus_ready cycle
//
// Build option: define LSU_TIMEOUT_EN to abort a transfer after TIMEOUT_CYC
// bus cycles without bus_ready. Without it the controller waits forever and
// bus_err is tied low.

module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [3:0]  be_q;
  logic [2:0]  func3_q;
  logic        we_q, err_q;

  logic        req_any, req_misal, accept, capture, timeout_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_fmt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req_any = req_rd | req_wr;

  // Alignment check on the incoming request; func3[1:0] 1x is a word access.
  always_comb begin
    case (req_func3[1:0])
      2'b00:   req_misal = 1'b0;
      2'b01:   req_misal = req_addr[0];
      default: req_misal = |req_addr[1:0];
    endcase
  end

  // Store lane steering: replicate the datum across all lanes, enable only the target bytes.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension, from the address/func3 latched at accept.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_b = bus_rdata[7:0];
      2'b01:   lane_b = bus_rdata[15:8];
      2'b10:   lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (func3_q[1:0])
      2'b00:   load_fmt = {{24{lane_b[7] & ~func3_q[2]}}, lane_b};
      2'b01:   load_fmt = {{16{lane_h[15] & ~func3_q[2]}}, lane_h};
      default: load_fmt = bus_rdata;
    endcase
    if (we_q) begin
      load_fmt = '0;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q;

  // Fires in the BUS cycle whose missing ready would bring the count to TIMEOUT_CYC;
  // a ready in that same cycle still completes normally.
  assign timeout_hit = (state_q == StBus) && !bus_ready &&
                       (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == StBus) && !bus_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    misaligned = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_any) begin
          if (req_misal) begin
            misaligned = 1'b1;
          end else begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_d = StBus;
          end
        end
      end
      StBus: begin
        stall = 1'b1;
        if (bus_ready) begin
          capture = 1'b1;
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      func3_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        we_q    <= req_wr;
        func3_q <= req_func3;
        err_q   <= 1'b0;
      end
      if (capture) begin
        data_q <= load_fmt;
      end else if (timeout_hit) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  assign bus_valid = (state_q == StBus);
  assign bus_we    = bus_valid & we_q;
  assign bus_be    = bus_valid ? be_q : 4'b0000;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wdata = wdata_q;
  assign load_data = data_q;
  assign bus_err   = (state_q == StDone) & err_q;

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, meaning bus cycles waited for bus_ready before abort (used only with LSU_TIMEOUT_EN).
REQ-002 Single clock, synchronous active-high reset: all state changes on posedge clk; rst sampled only at posedge.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_rd  in  1  core load request, held stable while stall=1.
REQ-006 req_wr  in  1  core store request, held stable while stall=1.
REQ-007 req_addr  in  32  byte address (ALU result).
REQ-008 req_wdata  in  32  unaligned store data (rs2 value).
REQ-009 req_func3  in  3  access size/sign (RV32I load/store func3).
REQ-010 stall  out  1  core must hold PC and requests.
REQ-011 load_data  out  32  formatted load result, valid when done=1.
REQ-012 done  out  1  one-cycle pulse: access complete, core commits this cycle.
REQ-013 misaligned  out  1  one-cycle pulse: access rejected, no bus cycle.
REQ-014 bus_err  out  1  one-cycle pulse with done: timed-out access.
REQ-015 bus_valid/bus_we  out  1/1  bus request, write enable.
REQ-016 bus_addr  out  32  word address, bits [1:0] = 0.
REQ-017 bus_wdata/bus_be  out  32/4  lane-replicated store data, byte enables.
REQ-018 bus_ready  in  1  slave accepts/completes in the cycle it is high with bus_valid.
REQ-019 bus_rdata  in  32  read word, valid in the bus_ready cycle.

Function
REQ-020 FSM states IDLE, BUS, DONE; stall = (state==IDLE & request & aligned) | state==BUS.
REQ-021 IDLE: aligned request -> BUS; misaligned request -> misaligned=1 combinationally, stay IDLE, stall=0.
REQ-022 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0; byte never misaligned.
REQ-023 req_rd and req_wr both high -> treated as store.
REQ-024 BUS: bus_valid=1 with addr/we/wdata/be stable; bus_ready=1 -> capture data, -> DONE.
REQ-025 DONE: done=1, stall=0, load_data from capture register; -> IDLE unconditionally (no new request accepted in DONE).
REQ-026 Zero-wait latency: request at cycle N, bus_valid N+1, done N+2; each wait state adds one cycle.
REQ-027 Stores: sb be=0001<<addr[1:0], data byte replicated x4; sh be=0011<<{addr[1],1'b0}, halfword replicated x2; sw/func3[1:0]=11 be=1111.
REQ-028 Loads: lane selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged; func3 011/110/111 treated as lw.
REQ-029 load_data=0 for stores and for errored accesses.
REQ-030 Outside DONE, load_data holds last captured value; done, misaligned, bus_err low.

Reset
REQ-031 rst=1: state IDLE, bus_valid=0, bus_we=0, bus_be=0, load_data=0, timeout counter=0; done/misaligned/bus_err=0.
REQ-032 rst during BUS: request abandoned, bus_valid low the next cycle, no done pulse.
REQ-033 rst dominates all other inputs in the same cycle.

Configuration
REQ-034 Macro LSU_TIMEOUT_EN defined: counter clears on entry to BUS, increments each BUS cycle without bus_ready; reaching TIMEOUT_CYC -> DONE with bus_err=1, load_data=0, bus_valid dropped.
REQ-035 LSU_TIMEOUT_EN undefined: no counter, BUS waits indefinitely, bus_err tied 0.
REQ-036 bus_ready in the same cycle the counter reaches TIMEOUT_CYC -> normal completion, no bus_err.

Verification
REQ-037 lw addr 0x100, bus_ready tied 1, rdata 0xDEADBEEF -> bus_valid cycle N+1, done N+2, load_data 0xDEADBEEF, stall high 2 cycles.
REQ-038 lb addr 0x103, rdata 0x80FF_FFFF -> load_data 0xFFFF_FF80; lbu -> 0x0000_0080; lhu addr 0x102 -> 0x0000_80FF.
REQ-039 sh addr 0x206 wdata 0x1234ABCD -> bus_be 1100, bus_wdata 0xABCDABCD, bus_addr 0x204, bus_we=1.
REQ-040 lw addr 0x102 -> misaligned=1 same cycle, stall 0, bus_valid never asserted.
REQ-041 LSU_TIMEOUT_EN, TIMEOUT_CYC=4, bus_ready held 0 -> bus_err and done together 5 cycles after request, load_data 0.
REQ-042 rst pulsed in 2nd wait cycle of lw -> bus_valid 0 next cycle, no done, next request handled normally.
